des_key_shift: RTL and testbench
================================

# des_key_shift

Sequential DES key-schedule front end: accepts a 64-bit key, applies PC-1, then emits the 16 rotated 56-bit {C, D} register values, one per round, over a valid/ready stream. It sits directly upstream of the PC-2 permutation. Its cd56 output drives PC-2's 56-bit {C, D} input, and PC-2 turns each value into a 48-bit round key for the Feistel datapath.

## Interface
Parameters:
- None. The round count is fixed at 16 and the shift schedule is fixed by DES.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  block can accept a key; high only in IDLE.
- key_in  in  64  DES key, bit 63 = DES bit 1. Parity bits are ignored.
- decrypt  in  1  mode, sampled on key handshake. Present only with DES_KS_DECRYPT_EN.
- cd_valid  out  1  cd56 holds a valid round value.
- cd_ready  in  1  downstream accepts cd56.
- cd56  out  56  {C[27:0], D[27:0]} for the current round. cd56[55] = C bit 1.
- round_idx  out  4  output index 0..15.
- last  out  1  asserted with round_idx == 15.

## Operation
- States: IDLE, RUN.
- IDLE: key_ready = 1, cd_valid = 0.
- Key handshake (key_valid && key_ready) in IDLE:
  - PC-1(key_in) gives C0D0.
  - The mode is latched.
  - round_idx is set to 0 and the state goes to RUN.
  - cd56 is loaded with the first output value (see below).
- RUN: cd_valid = 1. On an output handshake (cd_valid && cd_ready):
  - round_idx < 15: round_idx increments and cd56 advances one step.
  - round_idx == 15: the state returns to IDLE.
- Shift schedule S[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - C and D rotate independently as 28-bit halves.
  - No bits cross between the halves.
- Encrypt:
  - First output = rotl(C0D0, S[0]).
  - Step from output r to r+1 = rotl by S[r+1].
  - Output r therefore equals C(r+1)D(r+1).
- Decrypt:
  - First output = C0D0 unrotated (equal to C16D16).
  - Step from output r to r+1 = rotr by S[15-r].
  - Output r therefore equals C(16-r)D(16-r).
- Backpressure: while cd_valid && !cd_ready, cd56, round_idx and last are held stable.
- key_in and decrypt are sampled only on the key handshake. They are don't-care at all other times.
- Reset mid-operation: rst_n low at any edge aborts the sequence. Remaining rounds are discarded, with no partial output.

## Timing
- Reset values (registered, valid the edge after rst_n low):
  - state = IDLE
  - cd_valid = 0
  - cd56 = 0
  - round_idx = 0
  - last = 0
  - Latched mode = encrypt
  - key_ready is forced to 0 while rst_n is low.
- Latency: key handshake at edge N gives cd_valid = 1 with round 0 after edge N.
- Throughput: one round per cycle with cd_ready held high. Rounds 0..15 occupy cycles N+1..N+16.
- Final handshake at edge M gives IDLE with key_ready = 1 after edge M. Minimum key period is 17 cycles.
- key_ready is never high in the same cycle as cd_valid. There is no overlap of keys.
- All outputs are driven from registers except key_ready, which is decoded from the state register and rst_n.

## Configuration
- DES_KS_DECRYPT_EN defined:
  - The decrypt port exists.
  - Right-rotate datapath and reversed schedule indexing are compiled in.
- DES_KS_DECRYPT_EN undefined:
  - No decrypt port.
  - Mode is always encrypt.
  - Only left-rotate logic is built.
  - 3DES decrypt passes must then be handled by downstream key buffering.

## Structure
- Shared package des_pkg holds:
  - Constant DES_ROUNDS = 16.
  - Shift-schedule constant array S.
  - State enum {IDLE, RUN}.
  - Typedefs for the 28-bit half and the 56-bit CD value.
- One sub-module, pc1_perm: purely combinational, 64-bit key in, 56-bit C0D0 out, instantiated once.
- The rotate-by-1/2 logic is local functions in the block.

## Test plan
- Encrypt, key 0x133457799BBCDFF1, cd_ready high:
  - Round 0 gives cd56 = 0xE19955FAACCF1E.
  - Round 15 gives cd56 = 0xF0CCAAF556678F, with last = 1.
  - PC-2 of round 0 = 0x1B02EFFC7072.
- Decrypt (macro on), same key:
  - Round 0 gives 0xF0CCAAF556678F.
  - Round 15 gives 0xE19955FAACCF1E.
  - The full sequence equals the encrypt sequence reversed.
- Backpressure: cd_ready low for 3 cycles at round 5. cd56 and round_idx = 5 stay stable; the sequence then completes with 16 outputs and no duplicates or gaps.
- Reset at round 7: rst_n low for one edge gives cd_valid = 0 and cd56 = 0. After release, key_ready = 1 and a new key restarts at round_idx = 0.
- Keys 0x0000000000000000 and 0xFFFFFFFFFFFFFFFF give cd56 all-zero and all-one respectively in every round.
- Key offered during RUN: key_valid held high is not accepted until the cycle after the last handshake. The key is then accepted exactly once.

Source files
------------

// File: rtl/des_pkg.sv
// Shared definitions for the DES key-schedule front end: round count,
// per-round left-shift schedule, FSM state type and C/D value types.
package des_pkg;

    localparam int unsigned DES_ROUNDS = 16;

    // Left-rotate amount applied to each 28-bit half when producing C(i)/D(i).
    localparam int unsigned S [DES_ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2,
                                               1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {IDLE, RUN} state_e;

    typedef logic [27:0] half_t;
    typedef logic [55:0] cd_t;

endpackage

// File: rtl/pc1_perm.sv
// DES Permuted Choice 1: 64-bit key (bit 63 = DES bit 1) to 56-bit C0D0
// (bit 55 = C bit 1). Purely combinational; the 8 parity bits are dropped.
module pc1_perm
    import des_pkg::*;
(
    input  logic [63:0] key_i,
    output cd_t         c0d0_o
);

    // Entry i is the DES key bit number (1-based, MSB first) feeding C0D0 bit i+1.
    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign c0d0_o[55-i] = key_i[64-PC1[i]];
    end

    // Parity bits (DES bits 8, 16, ..., 64) take no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

endmodule

// File: rtl/des_key_shift.sv
// DES key-schedule front end: PC-1 on a handshaken key, then 16 rotated
// {C, D} values streamed out one per accepted cycle for a downstream PC-2.
// Optional feature macro: DES_KS_DECRYPT_EN adds the decrypt port and the
// right-rotate datapath that walks the schedule backwards (C16D16 .. C1D1).
module des_key_shift
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
`ifdef DES_KS_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic        cd_valid,
    input  logic        cd_ready,
    output logic [55:0] cd56,
    output logic [3:0]  round_idx,
    output logic        last
);

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    cd_t         cd_q, cd_d;
    logic [3:0]  idx_q, idx_d;
    logic        last_q, last_d;
    cd_t         c0d0;
    logic [3:0]  nxt_idx;
`ifdef DES_KS_DECRYPT_EN
    logic        dec_q, dec_d;
    logic [3:0]  rev_idx;
`endif

    function automatic half_t rotl_half(input half_t h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic cd_t rotl_cd(input cd_t v, input logic two);
        return {rotl_half(v[55:28], two), rotl_half(v[27:0], two)};
    endfunction

`ifdef DES_KS_DECRYPT_EN
    function automatic half_t rotr_half(input half_t h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    function automatic cd_t rotr_cd(input cd_t v, input logic two);
        return {rotr_half(v[55:28], two), rotr_half(v[27:0], two)};
    endfunction
`endif

    pc1_perm u_pc1 (
        .key_i  (key_in),
        .c0d0_o (c0d0)
    );

    assign nxt_idx   = idx_q + 4'd1;
`ifdef DES_KS_DECRYPT_EN
    assign rev_idx   = 4'd15 - idx_q;
`endif
    assign key_ready = rst_n && (state_q == IDLE);
    assign cd_valid  = valid_q;
    assign cd56      = cd_q;
    assign round_idx = idx_q;
    assign last      = last_q;

    // Next-state: load first round on key handshake, advance on output handshake.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        cd_d    = cd_q;
        idx_d   = idx_q;
        last_d  = last_q;
`ifdef DES_KS_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (key_valid && key_ready) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    last_d  = 1'b0;
`ifdef DES_KS_DECRYPT_EN
                    dec_d   = decrypt;
                    // Decrypt starts at C16D16, which equals the unrotated C0D0.
                    cd_d    = decrypt ? c0d0 : rotl_cd(c0d0, S[0] == 2);
`else
                    cd_d    = rotl_cd(c0d0, S[0] == 2);
`endif
                end
            end
            RUN: begin
                if (cd_ready) begin
                    if (idx_q == 4'(DES_ROUNDS - 1)) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = nxt_idx;
                        last_d = (nxt_idx == 4'(DES_ROUNDS - 1));
`ifdef DES_KS_DECRYPT_EN
                        cd_d   = dec_q ? rotr_cd(cd_q, S[rev_idx] == 2)
                                       : rotl_cd(cd_q, S[nxt_idx] == 2);
`else
                        cd_d   = rotl_cd(cd_q, S[nxt_idx] == 2);
`endif
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            cd_q    <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cd_q    <= cd_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
`ifdef DES_KS_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

endmodule

// File: tb/tb_des_key_shift.sv
// Directed bench for des_key_shift. Honours DES_KS_DECRYPT_EN when defined.
module tb_des_key_shift;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [63:0] key_in;
`ifdef DES_KS_DECRYPT_EN
    logic        decrypt;
`endif
    logic        cd_valid;
    logic        cd_ready;
    logic [55:0] cd56;
    logic [3:0]  round_idx;
    logic        last;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [63:0] K1      = 64'h133457799BBCDFF1;
    localparam logic [55:0] K1_C0D0 = 56'hF0CCAAF556678F;

    // Cumulative left shift after round r (C(r+1) = rotl(C0, CUM[r])).
    localparam int CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    des_key_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
`ifdef DES_KS_DECRYPT_EN
        .decrypt   (decrypt),
`endif
        .cd_valid  (cd_valid),
        .cd_ready  (cd_ready),
        .cd56      (cd56),
        .round_idx (round_idx),
        .last      (last)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [55:0] pc1_model(input logic [63:0] k);
        logic [55:0] v;
        v = '0;
        for (int i = 0; i < 56; i++) v[6'(55 - i)] = k[6'(64 - PC1[i])];
        return v;
    endfunction

    function automatic logic [47:0] pc2_model(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int j = 0; j < 48; j++) o[6'(47 - j)] = cd[6'(56 - PC2[j])];
        return o;
    endfunction

    function automatic logic [55:0] exp_cd(input logic [55:0] c0d0, input int r, input bit dec);
        int n;
        logic [27:0] c;
        logic [27:0] d;
        n = dec ? CUM[15 - r] : CUM[r];
        c = c0d0[55:28];
        d = c0d0[27:0];
        for (int k = 0; k < n; k++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    task automatic send_key(input logic [63:0] k, input bit dec);
        int n;
        key_in    = k;
`ifdef DES_KS_DECRYPT_EN
        decrypt   = dec;
`else
        if (dec) $display("note: decrypt request ignored in this build");
`endif
        key_valid = 1'b1;
        n = 0;
        while (!key_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!key_ready) check_val("key_ready_timeout", 64'(key_ready), 64'd1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_in    = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    // Checks rounds 0..nrounds-1; handshakes all of them when nrounds == 16,
    // otherwise stops holding the last checked round.
    task automatic collect(input logic [55:0] c0d0, input bit dec, input int stall_at, input int nrounds);
        logic [55:0] exp;
        for (int r = 0; r < nrounds; r++) begin
            exp = exp_cd(c0d0, r, dec);
            check_val("cd_valid", 64'(cd_valid), 64'd1);
            check_val("round_idx", 64'(round_idx), 64'(r));
            check_val("cd56", 64'(cd56), 64'(exp));
            check_val("last", 64'(last), 64'(r == 15));
            check_val("key_ready_run", 64'(key_ready), 64'd0);
            if (r == stall_at) begin
                cd_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(posedge clk); #1;
                    check_val("bp_valid", 64'(cd_valid), 64'd1);
                    check_val("bp_idx", 64'(round_idx), 64'(r));
                    check_val("bp_cd56", 64'(cd56), 64'(exp));
                end
                cd_ready = 1'b1;
            end
            if (r < nrounds - 1 || nrounds == 16) begin
                @(posedge clk); #1;
            end
        end
        if (nrounds == 16) begin
            check_val("end_valid", 64'(cd_valid), 64'd0);
            check_val("end_key_ready", 64'(key_ready), 64'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        cd_ready  = 1'b1;
`ifdef DES_KS_DECRYPT_EN
        decrypt   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 64'(cd_valid), 64'd0);
        check_val("rst_cd56", 64'(cd56), 64'd0);
        check_val("rst_idx", 64'(round_idx), 64'd0);
        check_val("rst_last", 64'(last), 64'd0);
        check_val("rst_key_ready", 64'(key_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_key_ready", 64'(key_ready), 64'd1);

        // Reference key, encrypt, with a 3-cycle stall at round 5.
        send_key(K1, 1'b0);
        check_val("k1_round0", 64'(cd56), 64'h00E19955FAACCF1E);
        check_val("k1_pc2_round0", 64'(pc2_model(cd56)), 64'h00001B02EFFC7072);
        collect(K1_C0D0, 1'b0, 5, 16);

`ifdef DES_KS_DECRYPT_EN
        send_key(K1, 1'b1);
        check_val("k1_dec_round0", 64'(cd56), 64'h00F0CCAAF556678F);
        collect(K1_C0D0, 1'b1, -1, 16);
`endif

        // Abort mid-sequence at round 7.
        send_key(K1, 1'b0);
        collect(K1_C0D0, 1'b0, -1, 8);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("abort_valid", 64'(cd_valid), 64'd0);
        check_val("abort_cd56", 64'(cd56), 64'd0);
        check_val("abort_idx", 64'(round_idx), 64'd0);
        check_val("abort_key_ready", 64'(key_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check_val("abort_rel_key_ready", 64'(key_ready), 64'd1);
        send_key(64'h0123456789ABCDEF, 1'b0);
        collect(pc1_model(64'h0123456789ABCDEF), 1'b0, -1, 16);

        // All-zero and all-one keys.
        send_key(64'h0, 1'b0);
        collect(56'h0, 1'b0, -1, 16);
        send_key(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        collect(56'hFF_FFFF_FFFF_FFFF, 1'b0, -1, 16);

        // Second key held valid throughout RUN: taken only after the final handshake.
        send_key(64'hFEDCBA9876543210, 1'b0);
        key_in    = 64'h0E329232EA6D0D73;
        key_valid = 1'b1;
        collect(pc1_model(64'hFEDCBA9876543210), 1'b0, -1, 16);
        @(posedge clk); #1;
        key_valid = 1'b0;
        collect(pc1_model(64'h0E329232EA6D0D73), 1'b0, -1, 16);
        repeat (3) begin
            @(posedge clk); #1;
            check_val("single_accept_idle", 64'(cd_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
